crc_frame_ctrl: RTL and testbench

CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

---
 rtl/crc_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: frame sequencer for an external bit-serial CRC datapath.
// Accepts bytes on a valid/ready port, issues one load per frame and eight
// MSB-first shift commands per byte, then captures and holds the final CRC
// and frame length until the consumer takes them.
module crc_frame_ctrl #(
    parameter int unsigned   N       = 8,
    parameter logic [N-1:0]  POLY    = N'(8'h07),
    parameter logic [N-1:0]  INIT    = '0,
    parameter logic [N-1:0]  XOR_OUT = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    in_data_i,
    input  logic          in_valid_i,
    input  logic          in_last_i,
    output logic          in_ready_o,
    input  logic          abort_i,
    output logic          lfsr_load_o,
    output logic          lfsr_shift_o,
    output logic          lfsr_data_o,
    output logic [N-1:0]  lfsr_taps_o,
    output logic [N-1:0]  lfsr_init_o,
    input  logic [N-1:0]  lfsr_value_i,
    output logic [N-1:0]  crc_out_o,
    output logic [15:0]   frame_len_o,
    output logic          crc_valid_o,
    input  logic          crc_ready_i,
    output logic          busy_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LEN_W  = 16;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_NEXT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_OUT     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic                last_q, last_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [N-1:0]        crc_q, crc_d;
    logic [LEN_W-1:0]    flen_q, flen_d;

    logic                in_ready_q, in_ready_d;
    logic                load_q, load_d;
    logic                shift_q, shift_d;
    logic                data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic                accept;

    // The datapath configuration is fixed by parameters.
    assign lfsr_taps_o = POLY;
    assign lfsr_init_o = INIT;

    assign in_ready_o   = in_ready_q;
    assign lfsr_load_o  = load_q;
    assign lfsr_shift_o = shift_q;
    assign lfsr_data_o  = data_q;
    assign crc_out_o    = crc_q;
    assign frame_len_o  = flen_q;
    assign crc_valid_o  = valid_q;
    assign busy_o       = busy_q;

    // Next-state, datapath-register and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        len_d   = len_q;
        crc_d   = crc_q;
        flen_d  = flen_q;

        accept = in_valid_i & ~abort_i &
                 ((state_q == ST_IDLE) || (state_q == ST_NEXT));

        if (abort_i && (state_q != ST_IDLE)) begin
            // Abort drops the frame (and any pending result) without side effects.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_LOAD;
                        byte_d  = in_data_i;
                        last_d  = in_last_i;
                        len_d   = LEN_W'(1);
                        cnt_d   = '0;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
                ST_SHIFT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        state_d = last_q ? ST_CAPTURE : ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (accept) begin
                        state_d = ST_SHIFT;
                        byte_d  = in_data_i;
                        last_d  = in_last_i;
                        cnt_d   = '0;
                        len_d   = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state_d = ST_OUT;
                    crc_d   = lfsr_value_i ^ XOR_OUT;
                    flen_d  = len_q;
                end
                ST_OUT: begin
                    if (crc_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the upcoming state so they register with it.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_NEXT);
        load_d     = (state_d == ST_LOAD);
        shift_d    = (state_d == ST_SHIFT);
        data_d     = shift_d ? byte_d[CNT_W'(7) - cnt_d] : 1'b0;
        valid_d    = (state_d == ST_OUT);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, frame registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            len_q      <= '0;
            crc_q      <= '0;
            flen_q     <= '0;
            in_ready_q <= 1'b1;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            flen_q     <= flen_d;
            in_ready_q <= in_ready_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: an 8-bit and a 16-bit instance share one stimulus
// stream, each driving its own serial CRC datapath model. Results are compared
// with a byte-wise CRC reference and with known check values.
module tb_crc_frame_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        abort;
    logic        crc_ready;

    logic        in_ready8, load8, shift8, data8, valid8, busy8;
    logic [7:0]  taps8, init8, val8, crc8;
    logic [15:0] len8;

    logic        in_ready16, load16, shift16, data16, valid16, busy16;
    logic [15:0] taps16, init16, val16, crc16;
    logic [15:0] len16;

    int          checks   = 0;
    int          failures = 0;

    logic [7:0]  fq[$];

    crc_frame_ctrl #(.N(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)) dut8 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready8), .abort_i(abort),
        .lfsr_load_o(load8), .lfsr_shift_o(shift8), .lfsr_data_o(data8),
        .lfsr_taps_o(taps8), .lfsr_init_o(init8), .lfsr_value_i(val8),
        .crc_out_o(crc8), .frame_len_o(len8), .crc_valid_o(valid8),
        .crc_ready_i(crc_ready), .busy_o(busy8)
    );

    crc_frame_ctrl #(.N(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) dut16 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready16), .abort_i(abort),
        .lfsr_load_o(load16), .lfsr_shift_o(shift16), .lfsr_data_o(data16),
        .lfsr_taps_o(taps16), .lfsr_init_o(init16), .lfsr_value_i(val16),
        .crc_out_o(crc16), .frame_len_o(len16), .crc_valid_o(valid16),
        .crc_ready_i(crc_ready), .busy_o(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial LFSR datapaths commanded by each controller.
    always @(posedge clk) begin
        if (rst)         val8 <= '0;
        else if (load8)  val8 <= init8;
        else if (shift8) val8 <= {val8[6:0], 1'b0} ^ ((val8[7] ^ data8) ? taps8 : 8'h00);
    end

    always @(posedge clk) begin
        if (rst)          val16 <= '0;
        else if (load16)  val16 <= init16;
        else if (shift16) val16 <= {val16[14:0], 1'b0} ^ ((val16[15] ^ data16) ? taps16 : 16'h0000);
    end

    // Byte-wise CRC of the frame in fq.
    function automatic logic [15:0] crc_ref(input int n, input int poly, input int init, input int xo);
        int c;
        int mask;
        mask = (1 << n) - 1;
        c = init;
        foreach (fq[k]) begin
            c = c ^ (int'(fq[k]) << (n - 8));
            for (int b = 0; b < 8; b++) begin
                if ((c & (1 << (n - 1))) != 0) c = ((c << 1) ^ poly) & mask;
                else                           c = (c << 1) & mask;
            end
        end
        return 16'((c ^ xo) & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs of both instances against one expected vector.
    task automatic ctl(input string tag, input logic r, input logic l, input logic s,
                       input logic d, input logic b, input logic v);
        chk({tag, ".in_ready8"},  32'(in_ready8),  32'(r));
        chk({tag, ".load8"},      32'(load8),      32'(l));
        chk({tag, ".shift8"},     32'(shift8),     32'(s));
        chk({tag, ".data8"},      32'(data8),      32'(d));
        chk({tag, ".busy8"},      32'(busy8),      32'(b));
        chk({tag, ".valid8"},     32'(valid8),     32'(v));
        chk({tag, ".in_ready16"}, 32'(in_ready16), 32'(r));
        chk({tag, ".load16"},     32'(load16),     32'(l));
        chk({tag, ".shift16"},    32'(shift16),    32'(s));
        chk({tag, ".data16"},     32'(data16),     32'(d));
        chk({tag, ".busy16"},     32'(busy16),     32'(b));
        chk({tag, ".valid16"},    32'(valid16),    32'(v));
    endtask

    task automatic chk_reset_vals(input string tag);
        ctl(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".crc8"},  32'(crc8),  32'h0);
        chk({tag, ".len8"},  32'(len8),  32'h0);
        chk({tag, ".crc16"}, 32'(crc16), 32'h0);
        chk({tag, ".len16"}, 32'(len16), 32'h0);
    endtask

    // Offer one byte at a negedge, then follow load (first byte) and 8 shifts.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic first);
        ctl("accept", 1'b1, 1'b0, 1'b0, 1'b0, !first, 1'b0);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        if (first) begin
            in_valid = 1'b0;
            ctl("load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            ctl("shift", 1'b0, 1'b0, 1'b1, b[7 - i], 1'b1, 1'b0);
            // Junk on the input port while not ready must be ignored.
            in_valid = (i < 7);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Send all of fq, hold crc_ready low for 'hold' OUT cycles, optionally abort in OUT.
    task automatic run_frame(input int hold, input logic abort_out);
        logic [15:0] e8, e16;
        int n;
        n = fq.size();
        crc_ready = (hold == 0);
        for (int k = 0; k < n; k++) send_byte(fq[k], k == n - 1, k == 0);
        ctl("capture", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        e8  = crc_ref(8, 'h07, 'h00, 'h00);
        e16 = crc_ref(16, 'h1021, 'hFFFF, 'h0000);
        for (int h = 0; h <= hold; h++) begin
            ctl("out", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("out.crc8",  32'(crc8),  32'(e8));
            chk("out.len8",  32'(len8),  32'(n));
            chk("out.crc16", 32'(crc16), 32'(e16));
            chk("out.len16", 32'(len16), 32'(n));
            if (h == hold) begin
                crc_ready = 1'b1;
                abort     = abort_out;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        ctl("after_out", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_check_string();
        fq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        abort     = 1'b0;
        crc_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        chk("taps8",  32'(taps8),  32'h07);
        chk("init8",  32'(init8),  32'h00);
        chk("taps16", 32'(taps16), 32'h1021);
        chk("init16", 32'(init16), 32'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        ctl("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Standard check string.
        load_check_string();
        run_frame(0, 1'b0);
        chk("known8",  32'(crc8),  32'hF4);
        chk("known16", 32'(crc16), 32'h29B1);

        // Single zero byte: load, eight zero shifts, result after capture.
        fq = {8'h00};
        run_frame(0, 1'b0);
        chk("zero8", 32'(crc8), 32'h00);

        // Consumer back-pressure for 5 cycles.
        fq = {8'hA5, 8'h5A, 8'hFF};
        run_frame(5, 1'b0);

        // Abort during the 4th shift of the second byte.
        crc_ready = 1'b1;
        send_byte(8'h31, 1'b0, 1'b1);
        ctl("accept2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h32;
        in_last  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ctl("pre_abort", 1'b0, 1'b0, 1'b1, in_data[7 - i], 1'b1, 1'b0);
            @(negedge clk);
        end
        ctl("abort_shift", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ctl("aborted", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        load_check_string();
        run_frame(0, 1'b0);
        chk("abort_then8", 32'(crc8), 32'hF4);

        // Abort in IDLE with a valid byte: nothing accepted.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        ctl("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort while the result is offered drops it.
        fq = {8'h12, 8'h34};
        run_frame(2, 1'b1);

        // Reset in the middle of shifting.
        send_byte(8'h31, 1'b0, 1'b1);
        ctl("accept_r", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h32;
        @(negedge clk);
        in_valid = 1'b0;
        ctl("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        ctl("post_mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_check_string();
        run_frame(0, 1'b0);
        chk("rst_then8",  32'(crc8),  32'hF4);
        chk("rst_then16", 32'(crc16), 32'h29B1);

        // Random frames against the reference.
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(1, 5);
            fq.delete();
            for (int k = 0; k < len; k++) fq.push_back(8'($urandom));
            run_frame($urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
